design_04_pipe_alu: RTL and testbench
=====================================

Name: design_04_pipe_alu

Overview:
Parametrised successor to the fixed two-operand registered datapath block. Accepts operand pairs plus an opcode through a valid/ready handshake and computes one of four arithmetic ops. The result travels through a configurable-depth elastic pipeline with per-stage backpressure, synchronous flush and an occupancy count. Sits between the operand source and the result consumer; it replaces the start/valid control pulse with full flow control.

Parameters:
W, 20, operand and result width in bits (>=2)
STAGES, 3, pipeline depth = latency in cycles (1..8)
CW, 4, occupancy counter width; must satisfy 2**CW > STAGES

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight beats
in_valid  input  1  operand beat offered
in_ready  output  1  block can accept beat this cycle
op  input  2  00 add-wrap, 01 sub-wrap, 10 add-saturate (unsigned), 11 max (unsigned)
a  input  W  operand A, unsigned
b  input  W  operand B, unsigned
out_valid  output  1  result beat available
out_ready  input  1  consumer accepts result
y  output  W  result
flag  output  1  per-beat status: carry (00), borrow (01), saturated (10), a>=b (11)
occupancy  output  CW  number of valid beats in the pipeline, 0..STAGES

Behaviour:
- Reset (rst_n low, async): all stage valids 0, all data and flag registers 0, occupancy 0. Outputs after reset: out_valid=0, y=0, flag=0, in_ready=1. Reset deassertion is sampled synchronously with no glitch on outputs.
- Reset mid-operation: in-flight beats are discarded; no partial beat ever appears on the output.
- Accept: a beat is taken when in_valid && in_ready at a rising edge.
- Output handshake: a beat is consumed when out_valid && out_ready at a rising edge.
- Compute: combinational, on the input side. The result and flag enter stage 0 on accept.
  - 00: y = (a+b) mod 2^W; flag = carry out.
  - 01: y = (a-b) mod 2^W; flag = (a<b).
  - 10: y = min(a+b, 2^W-1); flag = carry out.
  - 11: y = max(a,b); flag = (a>=b).
- Pipeline: stages 0..STAGES-1, each holding {valid, y, flag}.
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1].
  - in_ready = adv[0] && !flush.
  - A stage loads from its predecessor when adv[i] is true. The stage's valid takes the predecessor's valid, or the accept for stage 0.
  - The data registers of a bubble stage may load don't-care values; y and flag are only meaningful while out_valid=1.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+STAGES-1, i.e. it is visible in cycle t+STAGES, provided there is no backpressure.
- Throughput: one beat per cycle with out_ready held high.
- Stall: when out_ready=0 the output beat holds y, flag and out_valid stable. Upstream bubbles are collapsed, so the pipeline fills to STAGES beats. in_ready then drops only when all stages are valid and out_ready=0.
- Full with simultaneous pop: if all stages are valid and out_ready=1, in_ready=1 and a push plus pop occurs in the same cycle.
- Ordering: strict FIFO; no reordering and no duplication.
- Flush (sync, high): at the next edge all valids clear and occupancy becomes 0. in_ready=0 during flush, so no beat is accepted. A beat presented with out_valid and out_ready in the flush cycle still counts as consumed. Flush has priority over every other event.
- Occupancy: +1 on accept, -1 on consume, unchanged when both or neither occur, 0 on flush. It never exceeds STAGES and never underflows.
- No combinational path from in_valid/a/b/op to out_valid/y/flag.
- A combinational path exists from out_ready to in_ready (ready chain).

Test Plan:
- Reset, STAGES=3, W=20: hold rst_n=0 with random inputs -> out_valid=0, y=0, flag=0, occupancy=0, in_ready=1. Pulse rst_n low while 2 beats are in flight -> the beats are lost and occupancy=0.
- Latency/ops: push a=0xFFFFF, b=0x00002 with op=00, 01, 10, 11 on back-to-back cycles, out_ready=1.
  - Outputs appear from cycle 3 in order: y=0x00001/flag=1, y=0xFFFFD/flag=0, y=0xFFFFF/flag=1, y=0xFFFFF/flag=1.
  - occupancy stays at 3 in steady state.
- Backpressure: out_ready=0 while pushing 5 beats -> exactly 3 accepted, in_ready=0, occupancy=3, output beat stable. Raise out_ready -> beats drain in order and the remaining 2 are accepted with no loss.
- Simultaneous push/pop when full: all stages full, out_ready=1, in_valid=1 -> in_ready=1, occupancy stays 3, throughput of 1 beat/cycle.
- Flush: 3 beats in flight with flush=1 and in_valid=1 -> in_ready=0, the next cycle has out_valid=0 and occupancy=0. A beat pushed after flush is the next output, 3 cycles later.
- Subtract boundary: op=01, a=0, b=1 -> y=0xFFFFF, flag=1. op=11, a=b=0x12345 -> y=0x12345, flag=1.

Source files
------------

// File: rtl/design_04_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module  : design_04_pipe_alu
// Brief   : Four-op unsigned ALU feeding an elastic valid/ready pipeline with
//           per-stage backpressure, synchronous flush and an occupancy count.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module design_04_pipe_alu #(
    parameter int W      = 20,
    parameter int STAGES = 3,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          flag,
    output logic [CW-1:0] occupancy
);

    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_SADD = 2'b10;
    localparam logic [1:0] c_OP_MAX  = 2'b11;

    logic [W:0]          sum;
    logic [W-1:0]        res_y;
    logic                res_f;
    logic                accept;
    logic                consume;
    logic [STAGES-1:0]   adv;
    logic [STAGES-1:0]   v_q;
    logic [STAGES-1:0]   f_q;
    logic [W-1:0]        y_q [STAGES];
    logic [CW-1:0]       occ_q;
    logic [CW-1:0]       occ_d;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res_y = sum[W-1:0];
        res_f = sum[W];
        case (op)
            c_OP_ADD: begin
                res_y = sum[W-1:0];
                res_f = sum[W];
            end
            c_OP_SUB: begin
                res_y = a - b;
                res_f = (a < b);
            end
            c_OP_SADD: begin
                res_y = sum[W] ? {W{1'b1}} : sum[W-1:0];
                res_f = sum[W];
            end
            c_OP_MAX: begin
                res_y = (a >= b) ? a : b;
                res_f = (a >= b);
            end
            default: begin
                res_y = sum[W-1:0];
                res_f = sum[W];
            end
        endcase
    end

    // A stage may advance unless it and every stage downstream of it is
    // occupied while the consumer stalls; this is the unrolled ready chain.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_adv
            assign adv[i] = out_ready || !(&v_q[STAGES-1:i]);
        end
    endgenerate

    assign in_ready = adv[0] && !flush;
    assign accept   = in_valid && in_ready;
    assign consume  = v_q[STAGES-1] && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            f_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                y_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (adv[0]) begin
                v_q[0] <= accept;
                y_q[0] <= res_y;
                f_q[0] <= res_f;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_q[i] <= v_q[i-1];
                    y_q[i] <= y_q[i-1];
                    f_q[i] <= f_q[i-1];
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !consume) begin
            occ_d = occ_q + CW'(1);
        end else if (!accept && consume) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign flag      = f_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_design_04_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_design_04_pipe_alu
// Brief   : Scoreboard bench for design_04_pipe_alu with an arithmetic
//           reference model, directed corner cases and random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_design_04_pipe_alu;

    localparam int W      = 20;
    localparam int STAGES = 3;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          flag;
    logic [CW-1:0] occupancy;

    design_04_pipe_alu #(.W(W), .STAGES(STAGES), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flag(flag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         f;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   exact    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   r;
        longint m = longint'(1) << W;
        longint x = longint'(av);
        longint z = longint'(bv);
        longint s = x + z;
        r.acc = 0;
        case (o)
            2'd0: begin r.y = W'(s % m);                   r.f = (s >= m); end
            2'd1: begin r.y = W'((x - z + m) % m);         r.f = (x < z);  end
            2'd2: begin r.y = W'((s >= m) ? m - 1 : s);    r.f = (s >= m); end
            default: begin r.y = W'((x > z) ? x : z);      r.f = (x >= z); end
        endcase
        return r;
    endfunction

    // Monitor / scoreboard: every handshake is evaluated at the falling edge
    // preceding the rising edge on which it takes effect.
    bit           have_prev = 1'b0;
    logic         prev_v, prev_rdy, prev_fl, prev_f;
    logic [W-1:0] prev_y;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            have_prev = 1'b0;
        end else begin
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("in_ready", 64'(in_ready),
                64'(!flush && !(q.size() == STAGES && !out_ready)));
            if (have_prev && prev_v && !prev_rdy && !prev_fl) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_y", 64'(y), 64'(prev_y));
                chk("stall_flag", 64'(flag), 64'(prev_f));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("pop_empty", 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("y", 64'(y), 64'(e.y));
                    chk("flag", 64'(flag), 64'(e.f));
                    if (exact) chk("latency", 64'(cyc - e.acc), 64'(STAGES - 1));
                    else       chk("latency_min", 64'(cyc - e.acc >= STAGES - 1), 64'(1));
                end
            end
            if (in_valid && in_ready) begin
                e = model(op, a, b);
                e.acc = cyc + 1;
                q.push_back(e);
            end
            if (flush) q.delete();
            have_prev = 1'b1;
            prev_v    = out_valid;
            prev_rdy  = out_ready;
            prev_fl   = flush;
            prev_y    = y;
            prev_f    = flag;
        end
    end

    task automatic step(input logic iv, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        step(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
        while ((q.size() != 0 || out_valid) && n < 50) begin
            step(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_timeout", 64'(n < 50), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [1:0]   bop [5];
    logic [W-1:0] ba  [5];
    logic [W-1:0] bb  [5];
    int           idx;
    int           n;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 2'd0;
        a = '0; b = '0; out_ready = 1'b0;

        // Reset held with random inputs.
        repeat (4) begin
            step(1'($urandom), 2'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_y", 64'(y), 64'(0));
            chk("rst_flag", 64'(flag), 64'(0));
            chk("rst_occupancy", 64'(occupancy), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(1));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // Four ops back to back on the same operands, exact latency.
        exact = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), 20'hFFFFF, 20'h00002, 1'b1, 1'b0);
            if (k == 3) chk("steady_occupancy", 64'(occupancy), 64'(STAGES));
        end
        drain();
        exact = 1'b0;

        // Backpressure: five beats offered while the consumer stalls.
        for (int k = 0; k < 5; k++) begin
            bop[k] = 2'($urandom); ba[k] = W'($urandom); bb[k] = W'($urandom);
        end
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, bop[idx], ba[idx], bb[idx], 1'b0, 1'b0);
            if (in_ready) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(3));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_occupancy", 64'(occupancy), 64'(STAGES));
        n = 0;
        while (idx < 5 && n < 20) begin
            step(1'b1, bop[idx], ba[idx], bb[idx], 1'b1, 1'b0);
            chk("full_pushpop_ready", 64'(in_ready), 64'(1));
            if (in_ready) idx++;
            n++;
        end
        chk("bp_remaining_accepted", 64'(idx), 64'(5));
        // Full pipeline with push and pop every cycle.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 2'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
            chk("full_ready", 64'(in_ready), 64'(1));
            chk("full_occupancy", 64'(occupancy), 64'(STAGES));
        end
        drain();

        // Flush with beats in flight and a beat offered.
        for (int k = 0; k < 3; k++)
            step(1'b1, 2'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
        step(1'b1, 2'd0, W'($urandom), W'($urandom), 1'b1, 1'b1);
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        step(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_occupancy", 64'(occupancy), 64'(0));
        exact = 1'b1;
        step(1'b1, 2'd1, 20'h00010, 20'h00003, 1'b1, 1'b0);
        drain();

        // Boundary operands.
        step(1'b1, 2'd1, 20'h00000, 20'h00001, 1'b1, 1'b0);
        step(1'b1, 2'd3, 20'h12345, 20'h12345, 1'b1, 1'b0);
        step(1'b1, 2'd2, 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0);
        step(1'b1, 2'd0, 20'h00000, 20'h00000, 1'b1, 1'b0);
        drain();
        exact = 1'b0;

        // Reset pulse with two beats in flight.
        step(1'b1, 2'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0);
        step(1'b1, 2'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_occupancy", 64'(occupancy), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < STAGES + 3; k++) begin
            step(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
            chk("midrst_no_output", 64'(out_valid), 64'(0));
        end

        // Random traffic with occasional flush.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom), 2'($urandom), W'($urandom), W'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        drain();
        chk("final_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
